// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings and helpers for the data SRAM master
package dmem_pkg;
    localparam int XLEN = 64;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RESP
    } state_t;

    function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] offset);
        logic [7:0] base;
        case (size)
            SIZE_B:  base = 8'h01;
            SIZE_H:  base = 8'h03;
            SIZE_W:  base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << offset;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] offset);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return offset[0];
            SIZE_W:  return |offset[1:0];
            default: return |offset;
        endcase
    endfunction
endpackage

// File: rtl/dmem_load_align.sv
// rtl/dmem_load_align.sv - shifts a 64-bit SRAM word to the access offset and extends it
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      offset,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] result
);
    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (size)
            SIZE_B:  result = {{56{shifted[7]  & ~is_unsigned}}, shifted[7:0]};
            SIZE_H:  result = {{48{shifted[15] & ~is_unsigned}}, shifted[15:0]};
            SIZE_W:  result = {{32{shifted[31] & ~is_unsigned}}, shifted[31:0]};
            default: result = shifted;
        endcase
    end
endmodule

// File: rtl/dmem_sram_master.sv
// rtl/dmem_sram_master.sv - load/store request channel to 64-bit byte-enable sync SRAM
module dmem_sram_master
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              sram_en,
    output logic [7:0]        sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [XLEN-1:0]   sram_wdata,
    input  logic [XLEN-1:0]   sram_rdata
);
    state_t          state;
    logic [2:0]      ld_offset;
    logic [1:0]      ld_size;
    logic            ld_unsigned;
    logic [XLEN-1:0] ld_result;
    logic            fire;
    logic            mis;
    logic            access;
    logic            unused_addr;

    // Gating with resetn keeps the SRAM strobes low for the whole reset window.
    assign req_ready = resetn & ((state == ST_IDLE) | ((state == ST_RESP) & rsp_ready));
    assign fire      = req_valid & req_ready;
    assign mis       = misaligned(req_size, req_addr[2:0]);
    assign access    = fire & ~mis;

    assign sram_en     = access;
    assign sram_we     = (access & req_we) ? byte_mask(req_size, req_addr[2:0]) : 8'h00;
    assign sram_addr   = req_addr[ADDR_W+2:3];
    assign unused_addr = ^req_addr[XLEN-1:ADDR_W+3];

    always_comb begin
        case (req_size)
            SIZE_B:  sram_wdata = {8{req_wdata[7:0]}};
            SIZE_H:  sram_wdata = {4{req_wdata[15:0]}};
            SIZE_W:  sram_wdata = {2{req_wdata[31:0]}};
            default: sram_wdata = req_wdata;
        endcase
    end

    dmem_load_align u_align (
        .rdata       (sram_rdata),
        .offset      (ld_offset),
        .size        (ld_size),
        .is_unsigned (ld_unsigned),
        .result      (ld_result)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            ld_offset   <= '0;
            ld_size     <= '0;
            ld_unsigned <= 1'b0;
        end else if (state == ST_LOAD) begin
            rsp_rdata <= ld_result;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
        end else if (fire) begin
            rsp_rdata   <= '0;
            rsp_err     <= mis;
            ld_offset   <= req_addr[2:0];
            ld_size     <= req_size;
            ld_unsigned <= req_unsigned;
            if (!mis && !req_we) begin
                rsp_valid <= 1'b0;
                state     <= ST_LOAD;
            end else begin
                rsp_valid <= 1'b1;
                state     <= ST_RESP;
            end
        end else if (state == ST_RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
        end
    end
endmodule

// File: tb/tb_dmem_sram_master.sv
// tb/tb_dmem_sram_master.sv - directed and randomized checks against a byte-level memory model
module tb_dmem_sram_master;
    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [63:0] rsp_rdata;
    logic        sram_en;
    logic [7:0]  sram_we;
    logic [13:0] sram_addr;
    logic [63:0] sram_wdata, sram_rdata;

    int checks = 0;
    int errors = 0;

    logic [63:0] sram_mem [0:16383];
    logic [7:0]  ref_mem  [0:131071];

    always #5 clk = ~clk;

    dmem_sram_master #(.ADDR_W(14)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // Synchronous SRAM with one-cycle read latency and per-byte write enables
    always @(posedge clk) begin
        if (sram_en) begin
            sram_rdata <= sram_mem[sram_addr];
            for (int i = 0; i < 8; i++)
                if (sram_we[i]) sram_mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=0x%016h expected=0x%016h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic ref_access(input logic we, input logic [1:0] size, input logic uns,
                              input logic [63:0] addr, input logic [63:0] wdata,
                              output logic [63:0] exp_rdata, output logic exp_err,
                              output logic [7:0] exp_mask);
        int n;
        int off;
        logic [16:0] idx;
        n = 1 << size;
        off = int'(addr[2:0]);
        exp_err = (off % n) != 0;
        exp_rdata = 64'h0;
        exp_mask = 8'h0;
        if (!exp_err) begin
            for (int i = 0; i < n; i++) begin
                idx = addr[16:0] + 17'(i);
                exp_mask[off + i] = 1'b1;
                if (we) ref_mem[idx] = wdata[8*i +: 8];
                else    exp_rdata[8*i +: 8] = ref_mem[idx];
            end
            if (!we && !uns && n < 8 && exp_rdata[8*n-1])
                exp_rdata = exp_rdata | (~64'h0 << (8*n));
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          output logic [7:0] we_s, output logic [63:0] wd_s,
                          output logic [63:0] rd);
        logic [63:0] exp_rd;
        logic        exp_err;
        logic [7:0]  exp_mask;
        int          w;
        int          lat;
        ref_access(we, size, uns, addr, wdata, exp_rd, exp_err, exp_mask);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        #1;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk); #1; w++;
        end
        chk("req_ready", 64'(req_ready), 64'(1));
        chk("sram_en", 64'(sram_en), 64'(!exp_err));
        chk("sram_we", 64'(sram_we), 64'((we && !exp_err) ? exp_mask : 8'h00));
        if (!exp_err) chk("sram_addr", 64'(sram_addr), 64'(addr[16:3]));
        we_s = sram_we;
        wd_s = sram_wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk); #1; lat++;
        end
        chk("latency", 64'(lat), 64'((exp_err || we) ? 1 : 2));
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", 64'(rsp_err), 64'(exp_err));
        rd = rsp_rdata;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0]  we_s;
        logic [63:0] wd_s, rd, e_rd, a;
        logic        e_err;
        logic [7:0]  e_mask;

        for (int i = 0; i < 16384; i++) sram_mem[i] = 64'h0;
        for (int i = 0; i < 131072; i++) ref_mem[i] = 8'h0;
        resetn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 64'h0; req_wdata = 64'h0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset rsp_rdata", rsp_rdata, 64'h0);
        chk("reset rsp_err", 64'(rsp_err), 64'(0));
        chk("reset sram_en", 64'(sram_en), 64'(0));
        @(negedge clk) resetn = 1'b1;
        #1;
        chk("post-reset req_ready", 64'(req_ready), 64'(1));

        // 1: doubleword round trip
        do_req(1'b1, 2'd3, 1'b0, 64'h10, 64'h1122334455667788, we_s, wd_s, rd);
        chk("t1 sram_we", 64'(we_s), 64'hFF);
        do_req(1'b0, 2'd3, 1'b0, 64'h10, 64'h0, we_s, wd_s, rd);
        chk("t1 ld", rd, 64'h1122334455667788);

        // 2: byte store over zeros and signed/unsigned byte loads
        do_req(1'b1, 2'd3, 1'b0, 64'h10, 64'h0, we_s, wd_s, rd);
        do_req(1'b1, 2'd0, 1'b0, 64'h13, 64'hAB, we_s, wd_s, rd);
        chk("t2 sram_we", 64'(we_s), 64'h08);
        chk("t2 sram_wdata", wd_s, 64'hABABABABABABABAB);
        do_req(1'b0, 2'd0, 1'b0, 64'h13, 64'h0, we_s, wd_s, rd);
        chk("t2 lb", rd, 64'hFFFFFFFFFFFFFFAB);
        do_req(1'b0, 2'd0, 1'b1, 64'h13, 64'h0, we_s, wd_s, rd);
        chk("t2 lbu", rd, 64'h00000000000000AB);

        // 3: word/half extraction from upper lanes
        do_req(1'b1, 2'd3, 1'b0, 64'h18, 64'h8765432100000000, we_s, wd_s, rd);
        do_req(1'b0, 2'd2, 1'b0, 64'h1C, 64'h0, we_s, wd_s, rd);
        chk("t3 lw", rd, 64'hFFFFFFFF87654321);
        do_req(1'b0, 2'd2, 1'b1, 64'h1C, 64'h0, we_s, wd_s, rd);
        chk("t3 lwu", rd, 64'h0000000087654321);
        do_req(1'b0, 2'd1, 1'b0, 64'h1E, 64'h0, we_s, wd_s, rd);
        chk("t3 lh", rd, 64'hFFFFFFFFFFFF8765);

        // 4: misaligned accesses
        do_req(1'b0, 2'd1, 1'b0, 64'h11, 64'h0, we_s, wd_s, rd);
        do_req(1'b1, 2'd2, 1'b0, 64'h22, 64'hDEADBEEF, we_s, wd_s, rd);
        do_req(1'b0, 2'd3, 1'b0, 64'h0C, 64'h0, we_s, wd_s, rd);
        chk("t4 sram_en after", 64'(sram_en), 64'(0));

        // 5: response backpressure then same-cycle accept on handshake
        idle();
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_unsigned = 1'b0; req_addr = 64'h18;
        #1;
        chk("t5 ready", 64'(req_ready), 64'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("t5 valid", 64'(rsp_valid), 64'(1));
        chk("t5 rdata", rsp_rdata, 64'h8765432100000000);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("t5 hold valid", 64'(rsp_valid), 64'(1));
            chk("t5 hold rdata", rsp_rdata, 64'h8765432100000000);
            chk("t5 hold err", 64'(rsp_err), 64'(0));
            chk("t5 hold req_ready", 64'(req_ready), 64'(0));
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 64'h20; req_wdata = 64'h5A;
        #1;
        chk("t5 accept ready", 64'(req_ready), 64'(1));
        chk("t5 accept en", 64'(sram_en), 64'(1));
        chk("t5 accept we", 64'(sram_we), 64'h01);
        ref_access(1'b1, 2'd0, 1'b0, 64'h20, 64'h5A, e_rd, e_err, e_mask);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("t5 store rsp", 64'(rsp_valid), 64'(1));
        chk("t5 store err", 64'(rsp_err), 64'(0));
        idle();
        chk("t5 drained", 64'(rsp_valid), 64'(0));

        // 6: reset while a read is in flight
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_addr = 64'h18;
        @(posedge clk); #1;
        req_valid = 1'b0;
        resetn = 1'b0;
        #1;
        chk("t6 valid in reset", 64'(rsp_valid), 64'(0));
        chk("t6 en in reset", 64'(sram_en), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        chk("t6 no response", 64'(rsp_valid), 64'(0));
        @(negedge clk) resetn = 1'b1;
        #1;
        chk("t6 ready after", 64'(req_ready), 64'(1));
        do_req(1'b0, 2'd3, 1'b0, 64'h18, 64'h0, we_s, wd_s, rd);
        chk("t6 ld", rd, 64'h8765432100000000);

        // Aliasing: 0x2_0000 maps onto word 0
        do_req(1'b1, 2'd3, 1'b0, 64'h20000, 64'hCAFEF00D12345678, we_s, wd_s, rd);
        do_req(1'b0, 2'd3, 1'b0, 64'h0, 64'h0, we_s, wd_s, rd);
        chk("alias ld", rd, 64'hCAFEF00D12345678);

        // Randomized traffic over a few words with random upper address bits
        for (int n = 0; n < 300; n++) begin
            a = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFE_003F;
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   a, {$urandom, $urandom}, we_s, wd_s, rd);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
